cam_frame_writer: RTL and testbench
===================================

# cam_frame_writer

Parametrised capture-side framebuffer writer between `camera_read` and the dual-port video buffer. It takes the camera pixel stream (RGB565, row/col), decimates by a power-of-two factor, applies optional X/Y mirroring and a wrapping vertical offset, converts pixel depth, and emits registered write strobes. Optional double-buffering with a tear-free bank swap is synchronised to the VGA start-of-frame.

## Interface
Parameters:
- `SCALE_LOG2`, 2: decimation shift; pixel kept when `col[S-1:0]==0` and `row[S-1:0]==0`; 0 means no decimation
- `FB_W`, 160: framebuffer width in pixels
- `FB_H`, 120: framebuffer height in pixels
- `ADDR_W`, 15: write address width; must satisfy `FB_W*FB_H <= 2**ADDR_W`
- `OUT_BPP`, 16: 16 passes RGB565 through; 12 packs RGB444 as `{R[4:1],G[5:2],B[4:1]}`
- `DOUBLE_BUF`, 1: 1 uses two banks with a swap handshake; 0 uses a single bank with `wr_bank`/`rd_bank` tied 0

Ports:
- `clk` in 1: pixel/system clock (25 MHz domain)
- `rst` in 1: synchronous, active-high reset
- `pix_valid` in 1: one-cycle strobe per camera pixel
- `pix_data` in 16: RGB565 pixel
- `pix_col` in 10, `pix_row` in 10: camera coordinates of `pix_data`
- `frame_done` in 1: one-cycle pulse, end of camera frame
- `rd_sof` in 1: one-cycle pulse, VGA start of frame (vblank entry)
- `cfg_mirror_x` in 1, `cfg_mirror_y` in 1: mirror enables, sampled with each pixel
- `cfg_yoffset` in 7: vertical offset, taken modulo `FB_H`
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out OUT_BPP, `wr_bank` out 1: buffer write port
- `rd_bank` out 1: bank the VGA reader must display
- `frame_cnt` out 8: completed camera frames, wraps at 255
- `drop_cnt` out 8: frames discarded while waiting for a swap, saturates at 255

## Operation
- Pixel acceptance: `pix_valid` & decimation match. Then `x=col>>S`, `y=row>>S`. Drop the pixel if `x>=FB_W` or `y>=FB_H`.
- Mirror: `xm = cfg_mirror_x ? FB_W-1-x : x`, `ym = cfg_mirror_y ? FB_H-1-y : y`.
- Offset: `yo = ym + cfg_yoffset`, minus `FB_H` if `>=FB_H`, and again if still `>=FB_H`. Result is always `< FB_H`.
- Address: `wr_addr = yo*FB_W + xm`, computed at full width with no truncation before the compare.
- Bank FSM (DOUBLE_BUF=1):
  - States `WRITE` and `WAIT_SWAP`. Reset: `WRITE`, `wr_bank=0`, `rd_bank=1`.
  - `WRITE` + `frame_done` and `rd_sof` in the same cycle: swap immediately (`rd_bank<=wr_bank`, `wr_bank<=~wr_bank`), stay in `WRITE`.
  - `WRITE` + `frame_done` only: go to `WAIT_SWAP`. Accepted pixels are discarded from then on.
  - `WAIT_SWAP` + `rd_sof`: swap, go to `WRITE`.
  - `WAIT_SWAP` + `frame_done`: increment `drop_cnt` (saturating), stay in `WAIT_SWAP`.
  - `rd_sof` in `WRITE` without `frame_done`: no effect.
- DOUBLE_BUF=0: never leaves `WRITE`, no discards, `drop_cnt` stays 0.
- `frame_cnt` increments on every `frame_done`, in any state.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the decimated/mirrored coordinates, data, and the bank.
  - Stage 2 registers the offset address and the formatted data.
- `wr_en` asserts exactly 2 cycles after the qualifying `pix_valid`; `wr_addr`, `wr_data` and `wr_bank` are valid in the same cycle.
- Bank is captured at stage 1. Pixels already in flight when a swap occurs complete into their original bank.
- Back-to-back `pix_valid` every cycle is supported; no stall and no backpressure.
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `wr_bank=0`, `rd_bank=DOUBLE_BUF`, `frame_cnt=0`, `drop_cnt=0`.
- Reset asserted mid-operation clears both pipeline valids in the same edge, so no write occurs on the following cycle.

## Structure
- Shared package `cam_pkg`:
  - RGB565 field slice constants (R 15:11, G 10:5, B 4:0).
  - Bank FSM state enum `bank_state_t {WRITE, WAIT_SWAP}`.
  - `rgb565_to_out` packing function.
- One sub-module, `cam_addr_pipe`: the two-stage coordinate→address/data pipeline, parametrised by `SCALE_LOG2/FB_W/FB_H/ADDR_W/OUT_BPP`.
- The bank FSM and counters stay in the top level of `cam_frame_writer`.

## Test plan
- Defaults, mirrors off, offset 0. Pixel at col=8, row=4, data 16'hF81F → 2 cycles later `wr_en=1`, `wr_addr=1*160+2=162`, `wr_data=16'hF81F`. Pixel at col=9 → no write.
- `cfg_mirror_x=1`, `cfg_mirror_y=1`, col=0, row=0 → `wr_addr=119*160+159=19199`. `cfg_yoffset=5` with mirrors off, row=119*4 → `yo=4`, `wr_addr=640`.
- col=640 (x=160) → no write. `OUT_BPP=12`, data 16'hFFFF → `wr_data=12'hFFF`.
- Bank handshake:
  - `frame_done` → `WAIT_SWAP`; following pixels produce no `wr_en`.
  - A second `frame_done` → `drop_cnt=1`.
  - `rd_sof` → `rd_bank=0`, `wr_bank=1`.
  - Simultaneous `frame_done`+`rd_sof` in `WRITE` → immediate swap.
- Pixel issued the cycle before a swap is written with the old `wr_bank`. Asserting `rst` one cycle after `pix_valid` → no `wr_en`, all outputs at reset values.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture-side framebuffer writer:
// RGB565 field positions, the bank-swap state type and the pixel-depth packer.
package cam_pkg;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [0:0] {
        WRITE     = 1'b0,
        WAIT_SWAP = 1'b1
    } bank_state_t;

    // 12-bit output keeps the top four bits of each channel, left in the low bits of the result.
    function automatic logic [15:0] rgb565_to_out(input logic [15:0] pix, input int out_bpp);
        logic [15:0] res;
        if (out_bpp == 12) begin
            res = {4'h0, pix[R_MSB:R_LSB+1], pix[G_MSB:G_LSB+2], pix[B_MSB:B_LSB+1]};
        end else begin
            res = pix;
        end
        return res;
    endfunction

endpackage

// File: rtl/cam_addr_pipe.sv
// Two-stage pipeline turning a camera pixel into a framebuffer write:
// stage 1 decimates/mirrors/bounds-checks, stage 2 applies the wrapping offset and formats data.
module cam_addr_pipe #(
    parameter int SCALE_LOG2 = 2,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 15,
    parameter int OUT_BPP    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic [9:0]        in_col,
    input  logic [9:0]        in_row,
    input  logic              in_mirror_x,
    input  logic              in_mirror_y,
    input  logic [6:0]        in_yoffset,
    input  logic              in_bank,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_BPP-1:0] out_data,
    output logic              out_bank
);
    import cam_pkg::*;

    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic [9:0] DEC_MASK = 10'((32'd1 << SCALE_LOG2) - 32'd1);

    logic [31:0] x_s, y_s, xm_s, ym_s, yo_s, addr_full_s;
    logic [15:0] fmt_s;
    logic        keep_s;

    logic          s1_valid_q, s1_valid_d;
    logic [XW-1:0] s1_x_q, s1_x_d;
    logic [YW-1:0] s1_y_q, s1_y_d;
    logic [6:0]    s1_yoff_q;
    logic [15:0]   s1_data_q;
    logic          s1_bank_q;

    logic               s2_valid_q;
    logic [ADDR_W-1:0]  s2_addr_q, s2_addr_d;
    logic [OUT_BPP-1:0] s2_data_q, s2_data_d;
    logic               s2_bank_q;

    // Stage 1 next state: decimation match, bounds check and mirroring.
    always_comb begin
        x_s    = 32'(in_col >> SCALE_LOG2);
        y_s    = 32'(in_row >> SCALE_LOG2);
        keep_s = in_valid
               && ((in_col & DEC_MASK) == 10'd0)
               && ((in_row & DEC_MASK) == 10'd0)
               && (x_s < 32'(FB_W))
               && (y_s < 32'(FB_H));
        if (in_mirror_x) begin
            xm_s = 32'(FB_W) - 32'd1 - x_s;
        end else begin
            xm_s = x_s;
        end
        if (in_mirror_y) begin
            ym_s = 32'(FB_H) - 32'd1 - y_s;
        end else begin
            ym_s = y_s;
        end
        s1_valid_d = keep_s;
        s1_x_d     = xm_s[XW-1:0];
        s1_y_d     = ym_s[YW-1:0];
    end

    // Stage 2 next state: offset wraps with at most two subtractions since offset < 128.
    always_comb begin
        yo_s = 32'(s1_y_q) + 32'(s1_yoff_q);
        if (yo_s >= 32'(FB_H)) begin
            yo_s = yo_s - 32'(FB_H);
        end else begin
            yo_s = yo_s;
        end
        if (yo_s >= 32'(FB_H)) begin
            yo_s = yo_s - 32'(FB_H);
        end else begin
            yo_s = yo_s;
        end
        addr_full_s = yo_s * 32'(FB_W) + 32'(s1_x_q);
        s2_addr_d   = addr_full_s[ADDR_W-1:0];
        fmt_s       = rgb565_to_out(s1_data_q, OUT_BPP);
        s2_data_d   = fmt_s[OUT_BPP-1:0];
    end

    // Pipeline registers; reset drops both valids in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_yoff_q  <= 7'd0;
            s1_data_q  <= 16'd0;
            s1_bank_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_bank_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_yoff_q  <= in_yoffset;
            s1_data_q  <= in_data;
            s1_bank_q  <= in_bank;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_addr_q <= s2_addr_d;
                s2_data_q <= s2_data_d;
                s2_bank_q <= s1_bank_q;
            end else begin
                s2_addr_q <= s2_addr_q;
                s2_data_q <= s2_data_q;
                s2_bank_q <= s2_bank_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_addr  = s2_addr_q;
    assign out_data  = s2_data_q;
    assign out_bank  = s2_bank_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-to-framebuffer writer: address/data pipeline plus the tear-free bank swap
// FSM and frame/drop counters.
module cam_frame_writer #(
    parameter int SCALE_LOG2 = 2,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 15,
    parameter int OUT_BPP    = 16,
    parameter int DOUBLE_BUF = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [15:0]        pix_data,
    input  logic [9:0]         pix_col,
    input  logic [9:0]         pix_row,
    input  logic               frame_done,
    input  logic               rd_sof,
    input  logic               cfg_mirror_x,
    input  logic               cfg_mirror_y,
    input  logic [6:0]         cfg_yoffset,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [OUT_BPP-1:0] wr_data,
    output logic               wr_bank,
    output logic               rd_bank,
    output logic [7:0]         frame_cnt,
    output logic [7:0]         drop_cnt
);
    import cam_pkg::*;

    bank_state_t state_q;
    logic        bank_q;
    logic        rd_bank_q;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  drop_cnt_q;
    logic        pipe_valid_s;

    // Pixels arriving while a finished frame waits for the reader are thrown away.
    always_comb begin
        if (state_q == WAIT_SWAP) begin
            pipe_valid_s = 1'b0;
        end else begin
            pipe_valid_s = pix_valid;
        end
    end

    cam_addr_pipe #(
        .SCALE_LOG2 (SCALE_LOG2),
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .ADDR_W     (ADDR_W),
        .OUT_BPP    (OUT_BPP)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (pipe_valid_s),
        .in_data     (pix_data),
        .in_col      (pix_col),
        .in_row      (pix_row),
        .in_mirror_x (cfg_mirror_x),
        .in_mirror_y (cfg_mirror_y),
        .in_yoffset  (cfg_yoffset),
        .in_bank     (bank_q),
        .out_valid   (wr_en),
        .out_addr    (wr_addr),
        .out_data    (wr_data),
        .out_bank    (wr_bank)
    );

    // Bank swap FSM and counters; a swap only happens at a reader start-of-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WRITE;
            bank_q      <= 1'b0;
            rd_bank_q   <= 1'(DOUBLE_BUF);
            frame_cnt_q <= 8'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (DOUBLE_BUF != 0) begin
                case (state_q)
                    WRITE: begin
                        if (frame_done && rd_sof) begin
                            rd_bank_q <= bank_q;
                            bank_q    <= ~bank_q;
                        end else if (frame_done) begin
                            state_q <= WAIT_SWAP;
                        end
                    end
                    WAIT_SWAP: begin
                        if (rd_sof) begin
                            rd_bank_q <= bank_q;
                            bank_q    <= ~bank_q;
                            state_q   <= WRITE;
                        end else if (frame_done && (drop_cnt_q != 8'hFF)) begin
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= WRITE;
                endcase
            end
        end
    end

    assign rd_bank   = rd_bank_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench: a default double-buffered instance and a 12-bpp single-bank
// instance share stimulus; expected writes are queued at issue and checked by monitors.
module tb_cam_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_col, pix_row;
    logic        frame_done, rd_sof, cfg_mirror_x, cfg_mirror_y;
    logic [6:0]  cfg_yoffset;

    logic        wr_en1, wr_bank1, rd_bank1;
    logic [14:0] wr_addr1;
    logic [15:0] wr_data1;
    logic [7:0]  frame_cnt1, drop_cnt1;

    logic        wr_en2, wr_bank2, rd_bank2;
    logic [14:0] wr_addr2;
    logic [11:0] wr_data2;
    logic [7:0]  frame_cnt2, drop_cnt2;

    always #5 clk = ~clk;

    cam_frame_writer dut1 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_col(pix_col), .pix_row(pix_row), .frame_done(frame_done), .rd_sof(rd_sof),
        .cfg_mirror_x(cfg_mirror_x), .cfg_mirror_y(cfg_mirror_y), .cfg_yoffset(cfg_yoffset),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_bank(wr_bank1),
        .rd_bank(rd_bank1), .frame_cnt(frame_cnt1), .drop_cnt(drop_cnt1)
    );

    cam_frame_writer #(.OUT_BPP(12), .DOUBLE_BUF(0)) dut2 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_col(pix_col), .pix_row(pix_row), .frame_done(frame_done), .rd_sof(rd_sof),
        .cfg_mirror_x(cfg_mirror_x), .cfg_mirror_y(cfg_mirror_y), .cfg_yoffset(cfg_yoffset),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_bank(wr_bank2),
        .rd_bank(rd_bank2), .frame_cnt(frame_cnt2), .drop_cnt(drop_cnt2)
    );

    typedef struct {
        int issue;
        int addr;
        int data;
        bit bank;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference state of the bank handshake, tracked from the rules directly.
    bit   m_waiting;
    bit   m_wbank;
    bit   m_rbank;
    int   m_frames;
    int   m_drops;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_write(input int col, input int row, input bit mx, input bit my,
                                       input int yoff, output int addr);
        int x, y;
        addr = 0;
        if ((col % 4) != 0 || (row % 4) != 0) return 1'b0;
        x = col / 4;
        y = row / 4;
        if (x >= 160 || y >= 120) return 1'b0;
        if (mx) x = 159 - x;
        if (my) y = 119 - y;
        y = (y + yoff) % 120;
        addr = y * 160 + x;
        return 1'b1;
    endfunction

    task automatic step(input bit pv, input int col, input int row, input int d,
                        input bit mx, input bit my, input int yoff,
                        input bit fd, input bit sof, input bit r);
        int   a;
        exp_t e;
        rst          = r;
        pix_valid    = pv;
        pix_col      = 10'(col);
        pix_row      = 10'(row);
        pix_data     = 16'(d);
        cfg_mirror_x = mx;
        cfg_mirror_y = my;
        cfg_yoffset  = 7'(yoff);
        frame_done   = fd;
        rd_sof       = sof;
        if (r) begin
            q1.delete();
            q2.delete();
            m_waiting = 1'b0; m_wbank = 1'b0; m_rbank = 1'b1; m_frames = 0; m_drops = 0;
        end else begin
            if (pv && model_write(col, row, mx, my, yoff, a)) begin
                e.issue = cyc; e.addr = a;
                e.data = ((d >> 12) & 'hF) << 8 | ((d >> 7) & 'hF) << 4 | ((d >> 1) & 'hF);
                e.bank = 1'b0;
                q2.push_back(e);
                if (!m_waiting) begin
                    e.data = d; e.bank = m_wbank;
                    q1.push_back(e);
                end
            end
            if (fd) m_frames = (m_frames + 1) % 256;
            if (!m_waiting) begin
                if (fd && sof) begin m_rbank = m_wbank; m_wbank = !m_wbank; end
                else if (fd) m_waiting = 1'b1;
            end else begin
                if (sof) begin m_rbank = m_wbank; m_wbank = !m_wbank; m_waiting = 1'b0; end
                else if (fd && m_drops < 255) m_drops++;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_bank", 32'(rd_bank1), 32'(m_rbank));
        chk("frame_cnt", 32'(frame_cnt1), 32'(m_frames));
        chk("drop_cnt", 32'(drop_cnt1), 32'(m_drops));
        chk("sb_frame_cnt", 32'(frame_cnt2), 32'(m_frames));
        chk("sb_drop_cnt", 32'(drop_cnt2), 32'd0);
        chk("sb_rd_bank", 32'(rd_bank2), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor for the double-buffered 16-bpp instance.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("db_unexpected_write", 32'(wr_addr1), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("db_latency", 32'(cyc), 32'(e.issue + 2));
                chk("db_wr_addr", 32'(wr_addr1), 32'(e.addr));
                chk("db_wr_data", 32'(wr_data1), 32'(e.data));
                chk("db_wr_bank", 32'(wr_bank1), 32'(e.bank));
            end
        end
    end

    // Monitor for the single-bank 12-bpp instance.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("sb_unexpected_write", 32'(wr_addr2), 32'hFFFF_FFFF);
            end else begin
                e = q2.pop_front();
                chk("sb_latency", 32'(cyc), 32'(e.issue + 2));
                chk("sb_wr_addr", 32'(wr_addr2), 32'(e.addr));
                chk("sb_wr_data", 32'(wr_data2), 32'(e.data));
                chk("sb_wr_bank", 32'(wr_bank2), 32'(e.bank));
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_wr_en", 32'(wr_en1), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr1), 32'd0);
        chk("rst_wr_data", 32'(wr_data1), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank1), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank1), 32'd1);

        step(1, 8, 4, 'hF81F, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("basic_wr_en", 32'(wr_en1), 32'd1);
        chk("basic_addr", 32'(wr_addr1), 32'd162);
        chk("basic_data", 32'(wr_data1), 32'hF81F);
        step(1, 9, 4, 'h1234, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("decim_no_write", 32'(wr_en1), 32'd0);

        step(1, 0, 0, 'h0001, 1, 1, 0, 0, 0, 0);
        idle(1);
        chk("mirror_addr", 32'(wr_addr1), 32'd19199);
        step(1, 0, 476, 'h0002, 0, 0, 5, 0, 0, 0);
        idle(1);
        chk("offset_addr", 32'(wr_addr1), 32'd640);
        step(1, 640, 0, 'h0003, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("oob_no_write", 32'(wr_en1), 32'd0);
        step(1, 4, 4, 'hFFFF, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("bpp12_data", 32'(wr_data2), 32'hFFF);

        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 12, 8, 'hAAAA, 0, 0, 0, 0, 0, 0);
        step(1, 16, 8, 'h5555, 0, 0, 0, 0, 0, 0);
        chk("wait_no_write", 32'(wr_en1), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("drop_one", 32'(drop_cnt1), 32'd1);
        step(1, 20, 8, 'h1111, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("swap_rd_bank", 32'(rd_bank1), 32'd0);
        step(1, 24, 8, 'h2222, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("imm_swap_rd_bank", 32'(rd_bank1), 32'd1);
        step(1, 28, 8, 'h3333, 0, 0, 0, 0, 0, 0);
        idle(3);

        step(1, 8, 4, 'hBEEF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("midrst_wr_en", 32'(wr_en1), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr1), 32'd0);
        chk("midrst_wr_data", 32'(wr_data1), 32'd0);
        chk("midrst_rd_bank", 32'(rd_bank1), 32'd1);
        idle(1);
        chk("midrst_no_write", 32'(wr_en1), 32'd0);

        for (int i = 0; i < 800; i++) begin
            int  col, row;
            bit  fd, sof;
            if ($urandom_range(3) != 0) begin
                col = $urandom_range(179) * 4;
                row = $urandom_range(129) * 4;
            end else begin
                col = $urandom_range(1023);
                row = $urandom_range(1023);
            end
            fd  = ($urandom_range(39) == 0);
            sof = ($urandom_range(29) == 0);
            if (m_waiting && sof) fd = 1'b0;
            step($urandom_range(9) < 7, col, row, $urandom_range(65535),
                 $urandom_range(1), $urandom_range(1), $urandom_range(127), fd, sof, 0);
        end
        idle(5);
        chk("db_queue_drained", 32'(q1.size()), 32'd0);
        chk("sb_queue_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
